// File: rtl/if_stage_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package if_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP           = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_chk.sv
// Protocol and bookkeeping assertions for the fetch stage.
module if_stage_chk #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2,
  parameter int SUM_W = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             rvalid_i,
  input logic             pcq_valid_i,
  input logic [CNT_W-1:0] pcq_cnt_i,
  input logic [CNT_W-1:0] pend_i,
  input logic [SUM_W-1:0] credit_i
);

  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_i |-> pcq_valid_i);

  a_pcq_tracks_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pcq_cnt_i == pend_i);

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_i <= SUM_W'(DEPTH));

endmodule

// File: rtl/if_stage_sync_fifo.sv
// Synchronous FIFO with flush and a registered head: head_o/valid_o already
// hold the entry that will be at the front after this cycle's push/pop.
module if_stage_sync_fifo #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);

  // Next pointers/count and the entry that becomes the new head
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    head_d  = EMPTY_VAL;
    valid_d = 1'b0;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + PTR_W'(pop_ok);
      wr_d  = wr_q + PTR_W'(push_ok);
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      // The incoming word is the new head when it lands in the slot rd_d points at
      if (cnt_d != '0) begin
        valid_d = 1'b1;
        head_d  = (push_ok && (wr_q == rd_d)) ? wdata_i : mem_q[rd_d];
      end else begin
        valid_d = 1'b0;
        head_d  = EMPTY_VAL;
      end
    end
  end

  // Storage array write
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  // Pointer, count and head registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      head_q  <= EMPTY_VAL;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: owns the PC, issues in-order imem requests under
// a credit limit, buffers responses for decode and flushes on redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] out_q, out_d, kill_q, kill_d;
  logic             req_en_q;
  logic [CNT_W-1:0] fifo_cnt, pcq_cnt;
  logic [SUM_W-1:0] credit;
  logic             grant, resp_keep, fifo_pop, head_valid, pcq_valid;
  logic [XLEN-1:0]  pcq_head;
  fetch_entry_t     head, wentry;

  // Killed responses still occupy credit until they come back
  assign credit    = SUM_W'(out_q) + SUM_W'(kill_q) + SUM_W'(fifo_cnt);
  assign imem_req  = req_en_q && (credit < SUM_W'(DEPTH)) && !redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign resp_keep = imem_rvalid && (kill_q == '0) && !redirect_valid;
  assign fifo_pop  = head_valid && !stall_d;

  assign wentry.pc    = pcq_head;
  assign wentry.instr = imem_rdata;

  // Next PC and outstanding/kill bookkeeping
  always_comb begin
    out_d      = out_q;
    kill_d     = kill_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      kill_d     = kill_q + out_q - CNT_W'(imem_rvalid);
      out_d      = '0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (imem_rvalid && (kill_q != '0)) begin
        kill_d = kill_q - CNT_W'(1);
      end else begin
        kill_d = kill_q;
      end
      out_d = out_q + CNT_W'(grant) - CNT_W'(resp_keep);
      if (grant) begin
        fetch_pc_d = pc_inc(fetch_pc_q);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
    end
  end

  // PC, counters and the post-reset request enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      kill_q     <= '0;
      req_en_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      kill_q     <= kill_d;
      req_en_q   <= 1'b1;
    end
  end

  if_stage_sync_fifo #(
    .WIDTH     (FETCH_W),
    .DEPTH     (DEPTH),
    .EMPTY_VAL ({32'h0000_0000, NOP_INSTR})
  ) u_fetch_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (resp_keep),
    .wdata_i (wentry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .valid_o (head_valid),
    .count_o (fifo_cnt)
  );

  // Never flushed: killed responses still pop their PC entry in order
  if_stage_sync_fifo #(
    .WIDTH     (XLEN),
    .DEPTH     (DEPTH),
    .EMPTY_VAL (32'h0000_0000)
  ) u_pc_queue (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (1'b0),
    .push_i  (grant),
    .wdata_i (fetch_pc_q),
    .pop_i   (imem_rvalid),
    .head_o  (pcq_head),
    .valid_o (pcq_valid),
    .count_o (pcq_cnt)
  );

  if_stage_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_chk (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rvalid_i    (imem_rvalid),
    .pcq_valid_i (pcq_valid),
    .pcq_cnt_i   (pcq_cnt),
    .pend_i      (out_q + kill_q),
    .credit_i    (credit)
  );

  assign instr_d    = head.instr;
  assign pc_d       = head.pc;
  assign valid_d    = head_valid;
  assign pc_plus4_d = pc_inc(head.pc);

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with an in-order 1-cycle imem model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, stall_d, valid_d;
  logic [31:0] redirect_pc, instr_d, pc_d, pc_plus4_d;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d)
  );

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        hold;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } row_t;

  row_t        tbl[$];
  logic [31:0] mq[$];
  logic        hold;
  int          errors = 0;
  int          checks = 0;

  function automatic row_t mk(logic s, logic rd, logic [31:0] rp, logic h,
                              logic rq, logic [31:0] a, logic v, logic [31:0] p);
    row_t r;
    r.stall = s; r.redir = rd; r.rpc = rp; r.hold = h;
    r.req = rq; r.addr = a; r.valid = v; r.pc = p;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: record grant/response, clock once, drive the next response.
  task automatic tick();
    logic        g;
    logic        rv;
    logic [31:0] ga;
    #1;
    g  = imem_req & imem_gnt;
    ga = imem_addr;
    rv = imem_rvalid;
    @(posedge clk);
    if (rv && mq.size() > 0) void'(mq.pop_front());
    if (g) mq.push_back(ga);
    @(negedge clk);
    if (mq.size() > 0 && !hold) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0] ^ XOR_KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic run_row(int i);
    row_t r;
    r = tbl[i];
    stall_d        = r.stall;
    redirect_valid = r.redir;
    redirect_pc    = r.rpc;
    hold           = r.hold;
    tick();
    chk($sformatf("row%0d imem_req", i), {31'h0, imem_req}, {31'h0, r.req});
    chk($sformatf("row%0d imem_addr", i), imem_addr, r.addr);
    chk($sformatf("row%0d valid_d", i), {31'h0, valid_d}, {31'h0, r.valid});
    chk($sformatf("row%0d pc_d", i), pc_d, r.pc);
    chk($sformatf("row%0d instr_d", i), instr_d, r.valid ? (r.pc ^ XOR_KEY) : 32'h0000_0013);
    chk($sformatf("row%0d pc_plus4_d", i), pc_plus4_d, r.pc + 32'd4);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, " imem_req"}, {31'h0, imem_req}, 32'h0);
    chk({tag, " valid_d"}, {31'h0, valid_d}, 32'h0);
    chk({tag, " instr_d"}, instr_d, 32'h0000_0013);
    chk({tag, " pc_d"}, pc_d, 32'h0);
    chk({tag, " pc_plus4_d"}, pc_plus4_d, 32'h4);
  endtask

  initial begin
    // stall, redir, rpc, hold | req, addr, valid, pc
    // startup stream, then a 5-cycle decode stall
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,  0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h4,  0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h8,  1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h8,  1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hC,  0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h10, 1, 32'h8));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 0, 0, 0, 0, 32'h10, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 32'hC));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h14, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h18, 1, 32'h10));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h18, 1, 32'h14));
    // redirect to 0x103 with two responses held in flight
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h1C, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h20, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h103, 0, 0, 32'h100, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h104, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h108, 1, 32'h100));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h108, 1, 32'h104));
    // redirect coinciding with rvalid, then a second redirect to 0x200
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h10C, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h110, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h1F0, 0, 0, 32'h1F0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h200, 0, 0, 32'h200, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h204, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h208, 1, 32'h200));
    // redirect under stall to the top of the address space, then wrap
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h4, 1, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h4, 1, 32'h0));
    // restart after mid-stream reset
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h4, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h8, 1, 32'h0));

    rst_n          = 1'b0;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall_d        = 1'b0;
    hold           = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) run_row(i);

    #2 rst_n = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    mq.delete();
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 32; i < tbl.size(); i++) run_row(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the RV32 pipeline; sits directly upstream of the decode stage and supplies its 32-bit instruction word plus PC.
- Owns the program counter.
- Issues in-order requests to instruction memory over a request/grant + response-valid handshake.
- Buffers returned instructions in a small FIFO so that decode stalls do not drop fetched words.
- Handles jump/branch redirects by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, max instructions outstanding plus buffered (FIFO and PC-queue depth); power of two, at least 2.
- NOP_INSTR, 32'h0000_0013, value driven on instr_d when valid_d=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (word aligned).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction.
- redirect_valid  in  1  jump/taken-branch redirect from execute.
- redirect_pc  in  32  redirect target.
- stall_d  in  1  decode not ready; hold the current output.
- instr_d  out  32  instruction to decode.
- pc_d  out  32  PC of instr_d.
- pc_plus4_d  out  32  pc_d + 4 (mod 2^32).
- valid_d  out  1  instr_d/pc_d are valid.

Behaviour:
- Reset (async assert, sync release):
  - pc <= RESET_PC; FIFO empty; outstanding count = 0; kill count = 0.
  - Outputs: imem_req=0, valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=4.
  - First request may be issued in the first cycle after rst_n deasserts.
- Issue rule: imem_req = (outstanding + fifo_count + kill_cnt < DEPTH) && !redirect_valid. imem_addr = pc.
  - On req && gnt: push pc into the PC queue, outstanding++, pc <= pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - An ungranted request may be withdrawn or have its address changed (the imem protocol permits this).
- Response:
  - On imem_rvalid with kill_cnt = 0: pop the PC queue, push {pc, rdata} into the FIFO, outstanding--.
  - On imem_rvalid with kill_cnt > 0: discard the response, kill_cnt--, pop the PC queue.
  - The credit rule guarantees the FIFO never overflows; an rvalid with no outstanding or killed request is an assertion failure.
- Output:
  - valid_d = FIFO non-empty. instr_d/pc_d come from the FIFO head, registered-output FIFO.
  - pc_plus4_d = pc_d + 4.
  - When valid_d=0: instr_d = NOP_INSTR, pc_d = 0.
- Pop: valid_d && !stall_d.
  - With stall_d=1, all outputs hold stable.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
- Latency: redirect or reset release to valid_d is at least 2 cycles (issue, then earliest response, then registered output).
- Redirect (single cycle, highest priority):
  - FIFO flushed, so valid_d=0 next cycle.
  - kill_cnt <= outstanding + kill_cnt, minus 1 if an rvalid is consumed this cycle.
  - outstanding <= 0; pc <= {redirect_pc[31:2], 2'b00}; no request issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - stall_d is ignored for flush purposes.
- Back-to-back redirects: each one reloads pc and accumulates kills correctly.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset release for pre-reset requests are not supported; imem must be reset alongside.

Decomposition:
- Shared package:
  - RV_NOP constant.
  - XLEN=32.
  - Reset PC default.
  - Fetch-entry struct/width {pc[31:0], instr[31:0]}.
- One sub-module: sync_fifo (parameterised width/depth, flush, count output, simultaneous push/pop at full). Instantiated for the fetch FIFO (width 64) and the PC queue (width 32).

Test Plan:
- Reset release with imem_gnt=1 and 1-cycle rvalid, rdata = addr ^ 32'hA5A5_0000 → requests to 0x0, 0x4, 0x8…; valid_d first rises 2 cycles after the first grant; pc_d/instr_d sequence matches; pc_plus4_d = pc_d + 4.
- Hold stall_d=1 for 5 cycles while streaming → at most DEPTH=2 entries outstanding or buffered; imem_req drops; output holds 0x8; after release, 0xC and 0x10 follow with no loss or duplication.
- Pulse redirect_valid with redirect_pc=32'h0000_0103 while 2 responses are in flight → both in-flight responses discarded; next imem_addr = 0x100; the next valid_d shows pc_d = 0x100.
- Redirect in the same cycle as an rvalid, then a second redirect to 0x200 one cycle later → neither stale instruction appears; first valid output has pc_d = 0x200.
- pc = 32'hFFFF_FFFC with a grant → next imem_addr = 0x0; pc_plus4_d for the 0xFFFF_FFFC entry = 0x0.
- Assert rst_n=0 asynchronously mid-stream → valid_d=0, instr_d=32'h13, imem_req=0 immediately; restart fetches from RESET_PC.
